// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine keypad front end.
//   N_ROWS / N_COLS / N_KEYS : 4x3 key matrix geometry, key index = row*N_COLS + col
//   KEY_CODE_W               : width of an encoded key index
//   scan_state_e             : column scan FSM encoding
//   key_popcount / lowest_key: helpers used by the debouncer
package vm_pkg;

  localparam int N_ROWS     = 4;
  localparam int N_COLS     = 3;
  localparam int N_KEYS     = 12;
  localparam int KEY_CODE_W = 4;

  typedef enum logic [1:0] {
    SCAN_IDLE  = 2'd0,
    SCAN_DRIVE = 2'd1,
    SCAN_EVAL  = 2'd2
  } scan_state_e;

  // Number of keys down in a snapshot (0..12 fits in 4 bits).
  function automatic logic [3:0] key_popcount(input logic [N_KEYS-1:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_KEYS; i++) cnt = cnt + {3'b000, v[i]};
    return cnt;
  endfunction

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [KEY_CODE_W-1:0] lowest_key(input logic [N_KEYS-1:0] v);
    logic [KEY_CODE_W-1:0] idx;
    idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = KEY_CODE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_matrix_scanner_debounce.sv
// Whole-scan debouncer for the key matrix.
//   clk, rst        : clock, asynchronous active-low reset
//   eval            : one-cycle strobe, snap holds a complete scan
//   snap[11:0]      : keys seen down during the last full scan
//   key_state       : debounced level, 1 = held
//   key_press       : one-cycle pulse of newly pressed keys (cycle after eval)
//   key_valid       : one-cycle pulse, high exactly when key_press is non-zero
//   key_code        : lowest index in key_press, updated with key_valid, else holds
//   ghost_err       : last evaluated scan had three or more keys down
module keypad_debounce
  import vm_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  eval,
  input  logic [N_KEYS-1:0]     snap,
  output logic [N_KEYS-1:0]     key_state,
  output logic [N_KEYS-1:0]     key_press,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  ghost_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);

  logic [N_KEYS-1:0] prev_snap;
  logic [CNT_W-1:0]  stable_cnt;
  logic [CNT_W-1:0]  cnt_next;
  logic [N_KEYS-1:0] new_press;
  logic              ghost;

  always_comb begin
    cnt_next = CNT_W'(1);
    if (snap == prev_snap) begin
      cnt_next = (stable_cnt == CNT_MAX) ? stable_cnt : stable_cnt + CNT_W'(1);
    end
  end

  assign new_press = snap & ~key_state;
  // Three keys down in a 4x3 matrix without diodes can fake a fourth, so such
  // scans are not trusted and do not become the comparison baseline.
  assign ghost     = (key_popcount(snap) >= 4'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_snap  <= '0;
      stable_cnt <= '0;
      key_state  <= '0;
      key_press  <= '0;
      key_valid  <= 1'b0;
      key_code   <= '0;
      ghost_err  <= 1'b0;
    end else begin
      key_press <= '0;
      key_valid <= 1'b0;
      if (eval) begin
        if (ghost) begin
          ghost_err  <= 1'b1;
          stable_cnt <= '0;
        end else begin
          ghost_err  <= 1'b0;
          prev_snap  <= snap;
          stable_cnt <= cnt_next;
          if (cnt_next == CNT_MAX && snap != key_state) begin
            key_state <= snap;
            // Releases clear bits here but contribute nothing to new_press.
            key_press <= new_press;
            key_valid <= |new_press;
            if (|new_press) key_code <= lowest_key(new_press);
          end
        end
      end
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad matrix scanner: drives one column low at a time, reads the rows
// back through a two-flop synchroniser and hands complete scans to the
// debouncer.
//   clk, rst   : clock, asynchronous active-low reset
//   scan_en    : 1 = scanning; 0 = columns idle high, scan restarts on return
//   row_n[3:0] : matrix rows, active-low, asynchronous
//   col_n[2:0] : matrix columns, one-hot active-low
//   key_state / key_press / key_valid / key_code / ghost_err : see keypad_debounce
//   dbg_state  : current scan FSM state
module keypad_matrix_scanner
  import vm_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scan_en,
  input  logic [N_ROWS-1:0]     row_n,
  output logic [N_COLS-1:0]     col_n,
  output logic [N_KEYS-1:0]     key_state,
  output logic [N_KEYS-1:0]     key_press,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic                  ghost_err,
  output scan_state_e           dbg_state
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  scan_state_e       state, state_d;
  logic [1:0]        col_idx, col_d;
  logic [DIV_W-1:0]  div, div_d;
  logic              capture;
  logic [N_ROWS-1:0] row_meta, row_sync;
  logic [N_KEYS-1:0] snap;
  logic              eval;

  // Rows idle high through the pull-ups, so the synchroniser resets high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SCAN_IDLE;
      col_idx <= '0;
      div     <= '0;
    end else begin
      state   <= state_d;
      col_idx <= col_d;
      div     <= div_d;
    end
  end

  always_comb begin
    state_d = state;
    col_d   = col_idx;
    div_d   = div;
    capture = 1'b0;
    if (!scan_en) begin
      state_d = SCAN_IDLE;
      col_d   = '0;
      div_d   = '0;
    end else begin
      case (state)
        SCAN_IDLE: begin
          state_d = SCAN_DRIVE;
          col_d   = '0;
          div_d   = '0;
        end
        SCAN_DRIVE: begin
          if (div == DIV_LAST) begin
            capture = 1'b1;
            div_d   = '0;
            if (col_idx == 2'd2) state_d = SCAN_EVAL;
            else                 col_d   = col_idx + 2'd1;
          end else begin
            div_d = div + DIV_W'(1);
          end
        end
        SCAN_EVAL: begin
          state_d = SCAN_DRIVE;
          col_d   = '0;
          div_d   = '0;
        end
        default: state_d = SCAN_IDLE;
      endcase
    end
  end

  always_comb begin
    col_n = '1;
    if (state == SCAN_DRIVE) col_n = ~(N_COLS'(1) << col_idx);
  end

  // Rows are sampled on the last cycle of each column slot so they have had
  // the whole slot (minus synchroniser delay) to settle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap <= '0;
    end else if (!scan_en) begin
      snap <= '0;
    end else if (capture) begin
      for (int r = 0; r < N_ROWS; r++) begin
        snap[r*N_COLS + int'(col_idx)] <= ~row_sync[r];
      end
    end
  end

  assign eval      = (state == SCAN_EVAL) && scan_en;
  assign dbg_state = state;

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .eval     (eval),
    .snap     (snap),
    .key_state(key_state),
    .key_press(key_press),
    .key_valid(key_valid),
    .key_code (key_code),
    .ghost_err(ghost_err)
  );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3 (13-cycle scan).
// A behavioural key matrix turns the held-key vector into row levels.
module tb_keypad_matrix_scanner;
  import vm_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int SCAN_CYC = 3 * SCAN_DIV + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        scan_en;
  logic [3:0]  row_n;
  logic [2:0]  col_n;
  logic [11:0] key_state;
  logic [11:0] key_press;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        ghost_err;
  scan_state_e dbg_state;
  logic [11:0] keys;

  int checks   = 0;
  int failures = 0;
  // Expected pulses: {key_press[11:0], key_code[3:0]}
  logic [15:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  keypad_matrix_scanner #(
    .SCAN_DIV      (SCAN_DIV),
    .DEBOUNCE_SCANS(DEB)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .scan_en  (scan_en),
    .row_n    (row_n),
    .col_n    (col_n),
    .key_state(key_state),
    .key_press(key_press),
    .key_valid(key_valid),
    .key_code (key_code),
    .ghost_err(ghost_err),
    .dbg_state(dbg_state)
  );

  // Key matrix: a row is pulled low when any held key in it sits on a driven column.
  always_comb begin
    row_n = '1;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(keys[r*3 +: 3] & ~col_n);
  end

  // ---------------- driver / check tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_val(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic expect_press(input logic [11:0] press, input logic [3:0] code);
    exp_q.push_back({press, code});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b1 && (key_valid || key_press != 12'h000)) begin
      check_val("pulse_valid", 16'(key_valid), 16'h0001);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual press=%h code=%0d expected no pulse", key_press, key_code);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        check_val("pulse_press", 16'(key_press), 16'(e[15:4]));
        check_val("pulse_code", 16'(key_code), 16'(e[3:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst     = 1'b0;
    scan_en = 1'b0;
    keys    = '0;
    wait_cyc(2);
    check_val("rst_col_n", 16'(col_n), 16'h0007);
    check_val("rst_key_state", 16'(key_state), 16'h0000);

    // 1: asynchronous reset mid-scan with key 5 held
    rst     = 1'b1;
    scan_en = 1'b1;
    keys    = 12'h020;
    wait_cyc(20);
    #3 rst = 1'b0;
    #1;
    check_val("areset_col_n", 16'(col_n), 16'h0007);
    check_val("areset_key_state", 16'(key_state), 16'h0000);
    check_val("areset_key_press", 16'(key_press), 16'h0000);
    check_val("areset_key_valid", 16'(key_valid), 16'h0000);
    check_val("areset_key_code", 16'(key_code), 16'h0000);
    check_val("areset_ghost_err", 16'(ghost_err), 16'h0000);
    keys = '0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check_val("first_col_n", 16'(col_n), 16'h0006);
    @(negedge clk);

    // 2: clean press of key 7, then release without a pulse
    keys[7] = 1'b1;
    expect_press(12'h080, 4'd7);
    wait_cyc(60);
    check_val("press7_state", 16'(key_state), 16'h0080);
    keys = '0;
    wait_cyc(60);
    check_val("release7_state", 16'(key_state), 16'h0000);

    // 3: key 4 bounces every scan for 5 scans, then stays down
    for (int i = 0; i < 5; i++) begin
      keys[4] = ~keys[4];
      wait_cyc(SCAN_CYC);
    end
    check_val("bounce4_state", 16'(key_state), 16'h0000);
    expect_press(12'h010, 4'd4);
    wait_cyc(60);
    check_val("stable4_state", 16'(key_state), 16'h0010);
    keys = '0;
    wait_cyc(60);
    check_val("release4_state", 16'(key_state), 16'h0000);

    // 4: keys 2 and 9 together
    keys = 12'h204;
    expect_press(12'h204, 4'd2);
    wait_cyc(60);
    check_val("simul_state", 16'(key_state), 16'h0204);
    keys = '0;
    wait_cyc(60);
    check_val("simul_release", 16'(key_state), 16'h0000);

    // 5: ghost pattern 0,1,3 then drop key 3
    keys = 12'h00B;
    wait_cyc(40);
    check_val("ghost_err_set", 16'(ghost_err), 16'h0001);
    check_val("ghost_state", 16'(key_state), 16'h0000);
    keys[3] = 1'b0;
    expect_press(12'h003, 4'd0);
    wait_cyc(30);
    check_val("ghost_err_clr", 16'(ghost_err), 16'h0000);
    wait_cyc(45);
    check_val("ghost_after_state", 16'(key_state), 16'h0003);
    keys = '0;
    wait_cyc(60);
    check_val("ghost_release", 16'(key_state), 16'h0000);

    // 6: scan_en dropped mid-slot while key 10 is held, key released meanwhile
    keys[10] = 1'b1;
    expect_press(12'h400, 4'd10);
    wait_cyc(60);
    check_val("press10_state", 16'(key_state), 16'h0400);
    wait_cyc(2);
    scan_en = 1'b0;
    wait_cyc(1);
    check_val("dis_col_n", 16'(col_n), 16'h0007);
    check_val("dis_state", 16'(dbg_state), 16'(SCAN_IDLE));
    keys = '0;
    wait_cyc(19);
    check_val("dis_col_n_end", 16'(col_n), 16'h0007);
    check_val("dis_key_state", 16'(key_state), 16'h0400);
    scan_en = 1'b1;
    wait_cyc(1);
    check_val("reen_col_n", 16'(col_n), 16'h0006);
    wait_cyc(60);
    check_val("reen_release", 16'(key_state), 16'h0000);

    wait_cyc(20);
    check_val("pending_pulses", 16'(exp_q.size()), 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
